alu_iter_exec: RTL and testbench

- Execute-stage consumer of the 4-bit ALUop produced by the ALU decoder.
- Takes one operation per valid/ready handshake and computes the result.
- Non-shift ops finish in one cycle. Shifts iterate one bit position per cycle, for area.
- Result is returned on a second valid/ready channel toward writeback/forwarding.
- All ALUop codes come from the `ALU_*` macros in ALUop.vh; numeric encodings are never hard-coded.

---
 rtl/alu_iter_exec_if.sv | 25 ++
 rtl/alu_iter_exec.sv | 170 +++++++++++++++++
 tb/tb_alu_iter_exec.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_iter_exec_if.sv
// Valid/ready channels for alu_iter_exec: an operation request and a result response.
// master = issue/writeback side, slave = the execute unit.
interface alu_iter_exec_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       alu_op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             illegal;

   modport master (
      output in_valid, alu_op, a, b, out_ready,
      input  in_ready, out_valid, result, illegal
   );

   modport slave (
      input  in_valid, alu_op, a, b, out_ready,
      output in_ready, out_valid, result, illegal
   );
endinterface

// File: rtl/alu_iter_exec.sv
// Execute-stage ALU: single-cycle ops, bit-serial shifts (one position per cycle).
// Define ALU_ITER_BARREL_EN to replace the serial shifter with a single-cycle barrel shifter.
`ifndef ALU_ADD
`define ALU_ADD    4'd0
`define ALU_SUB    4'd1
`define ALU_AND    4'd2
`define ALU_OR     4'd3
`define ALU_XOR    4'd4
`define ALU_SLT    4'd5
`define ALU_SLTU   4'd6
`define ALU_SLL    4'd7
`define ALU_SRL    4'd8
`define ALU_SRA    4'd9
`define ALU_COPY_A 4'd10
`define ALU_COPY_B 4'd11
`define ALU_XXX    4'd15
`endif

module alu_iter_exec #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input logic         clk,
   input logic         rst,
   alu_iter_exec_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               illegal_q, illegal_d;
   logic               accept;
   logic               is_shift;
   logic [WIDTH-1:0]   op_res;
   logic               op_ill;
   logic [SHAMT_W-1:0] shamt;

`ifndef ALU_ITER_BARREL_EN
   logic [WIDTH-1:0]   work_q, work_d;
   logic [SHAMT_W-1:0] count_q, count_d;
   logic [3:0]         sop_q, sop_d;
   logic [WIDTH-1:0]   shifted;
`endif

   assign shamt    = bus.b[SHAMT_W-1:0];
   assign accept   = bus.in_valid && bus.in_ready;
   assign is_shift = (bus.alu_op == `ALU_SLL) || (bus.alu_op == `ALU_SRL) ||
                     (bus.alu_op == `ALU_SRA);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         result_q  <= '0;
         illegal_q <= 1'b0;
`ifndef ALU_ITER_BARREL_EN
         work_q    <= '0;
         count_q   <= '0;
         sop_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         result_q  <= result_d;
         illegal_q <= illegal_d;
`ifndef ALU_ITER_BARREL_EN
         work_q    <= work_d;
         count_q   <= count_d;
         sop_q     <= sop_d;
`endif
      end
   end

   // Single-cycle datapath; shift codes only resolve here in the barrel build.
   always_comb begin
      op_res = '0;
      op_ill = 1'b0;
      case (bus.alu_op)
         `ALU_ADD:    op_res = bus.a + bus.b;
         `ALU_SUB:    op_res = bus.a - bus.b;
         `ALU_AND:    op_res = bus.a & bus.b;
         `ALU_OR:     op_res = bus.a | bus.b;
         `ALU_XOR:    op_res = bus.a ^ bus.b;
         `ALU_SLT:    op_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
         `ALU_SLTU:   op_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
         `ALU_COPY_A: op_res = bus.a;
         `ALU_COPY_B: op_res = bus.b;
`ifdef ALU_ITER_BARREL_EN
         `ALU_SLL:    op_res = bus.a << shamt;
         `ALU_SRL:    op_res = bus.a >> shamt;
         `ALU_SRA:    op_res = WIDTH'($signed(bus.a) >>> shamt);
`endif
         default:     op_ill = 1'b1;
      endcase
   end

`ifndef ALU_ITER_BARREL_EN
   always_comb begin
      if (sop_q == `ALU_SLL)      shifted = {work_q[WIDTH-2:0], 1'b0};
      else if (sop_q == `ALU_SRA) shifted = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      else                        shifted = {1'b0, work_q[WIDTH-1:1]};
   end
`endif

   always_comb begin
      state_d   = state_q;
      result_d  = result_q;
      illegal_d = illegal_q;
`ifndef ALU_ITER_BARREL_EN
      work_d    = work_q;
      count_d   = count_q;
      sop_d     = sop_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (state_q == DONE && bus.out_ready) state_d = IDLE;
            if (accept) begin
`ifndef ALU_ITER_BARREL_EN
               if (is_shift) begin
                  work_d  = bus.a;
                  count_d = shamt;
                  sop_d   = bus.alu_op;
                  if (shamt == '0) begin
                     result_d  = bus.a;
                     illegal_d = 1'b0;
                     state_d   = DONE;
                  end else begin
                     state_d   = SHIFT;
                  end
               end else
`endif
               begin
                  result_d  = op_res;
                  illegal_d = op_ill;
                  state_d   = DONE;
               end
            end
         end
`ifndef ALU_ITER_BARREL_EN
         SHIFT: begin
            work_d  = shifted;
            count_d = count_q - 1'b1;
            if (count_q == SHAMT_W'(1)) begin
               result_d  = shifted;
               illegal_d = 1'b0;
               state_d   = DONE;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      case (state_q)
         IDLE:    bus.in_ready = 1'b1;
         DONE: begin
            bus.in_ready  = bus.out_ready;
            bus.out_valid = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.result  = result_q;
   assign bus.illegal = illegal_q;

   logic unused_is_shift;
   assign unused_is_shift = is_shift;
endmodule

// File: tb/tb_alu_iter_exec.sv
// Directed self-checking bench for alu_iter_exec (both shifter builds).
`ifndef ALU_ADD
`define ALU_ADD    4'd0
`define ALU_SUB    4'd1
`define ALU_AND    4'd2
`define ALU_OR     4'd3
`define ALU_XOR    4'd4
`define ALU_SLT    4'd5
`define ALU_SLTU   4'd6
`define ALU_SLL    4'd7
`define ALU_SRL    4'd8
`define ALU_SRA    4'd9
`define ALU_COPY_A 4'd10
`define ALU_COPY_B 4'd11
`define ALU_XXX    4'd15
`endif

module tb_alu_iter_exec;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   int   n;

   alu_iter_exec_if #(.WIDTH(32)) bus ();

   alu_iter_exec #(.WIDTH(32), .SHAMT_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
      bus.in_valid = 1'b1;
      bus.alu_op   = op;
      bus.a        = av;
      bus.b        = bv;
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.alu_op    = `ALU_ADD;
      bus.a         = '0;
      bus.b         = '0;
      bus.out_ready = 1'b1;
      tick(); tick();
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_result", bus.result, 32'd0);
      chk("rst_illegal", 32'(bus.illegal), 32'd0);
      rst = 1'b0;
      tick();
      chk("idle_in_ready", 32'(bus.in_ready), 32'd1);

      // Basic arithmetic, streamed back to back with out_ready=1
      offer(`ALU_SUB, 32'd5, 32'd7);
      tick();
      chk("sub_valid", 32'(bus.out_valid), 32'd1);
      chk("sub_result", bus.result, 32'hFFFF_FFFE);
      chk("sub_illegal", 32'(bus.illegal), 32'd0);
      offer(`ALU_SLT, 32'hFFFF_FFFF, 32'd1);
      tick();
      chk("slt_result", bus.result, 32'd1);
      offer(`ALU_SLTU, 32'hFFFF_FFFF, 32'd1);
      tick();
      chk("sltu_result", bus.result, 32'd0);
      chk("stream_valid", 32'(bus.out_valid), 32'd1);
      offer(`ALU_AND, 32'hF0F0_1234, 32'h0FF0_FF00);
      tick();
      chk("and_result", bus.result, 32'h00F0_1200);
      offer(`ALU_OR, 32'hF000_0001, 32'h0000_0F10);
      tick();
      chk("or_result", bus.result, 32'hF000_0F11);
      offer(`ALU_COPY_A, 32'hDEAD_BEEF, 32'd9);
      tick();
      chk("copya_result", bus.result, 32'hDEAD_BEEF);
      bus.in_valid = 1'b0;
      tick();
      chk("drain_valid", 32'(bus.out_valid), 32'd0);

      // Shift: SRA by 4 (upper bits of b ignored)
      offer(`ALU_SRA, 32'h8000_0000, 32'h0000_0024);
      tick();
      bus.in_valid = 1'b0;
`ifndef ALU_ITER_BARREL_EN
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("sra_busy_ready%0d", i), 32'(bus.in_ready), 32'd0);
         chk($sformatf("sra_busy_valid%0d", i), 32'(bus.out_valid), 32'd0);
         tick();
      end
`endif
      chk("sra_valid", 32'(bus.out_valid), 32'd1);
      chk("sra_result", bus.result, 32'hF800_0000);
      offer(`ALU_SRA, 32'h8000_0000, 32'h0000_0000);
      tick();
      chk("sra0_valid", 32'(bus.out_valid), 32'd1);
      chk("sra0_result", bus.result, 32'h8000_0000);
      offer(`ALU_SRL, 32'h8000_0000, 32'd4);
      tick();
      bus.in_valid = 1'b0;
      n = 0;
      while (!bus.out_valid && n < 40) begin tick(); n++; end
      chk("srl_result", bus.result, 32'h0800_0000);
      offer(`ALU_SLL, 32'd3, 32'd3);
      tick();
      bus.in_valid = 1'b0;
      n = 0;
      while (!bus.out_valid && n < 40) begin tick(); n++; end
      chk("sll_result", bus.result, 32'h0000_0018);

      // Maximum shift amount: latency check
      offer(`ALU_SLL, 32'd1, 32'd31);
      tick();
      bus.in_valid = 1'b0;
      n = 0;
      while (!bus.out_valid && n < 40) begin tick(); n++; end
`ifndef ALU_ITER_BARREL_EN
      chk("sll31_extra_cycles", 32'(n), 32'd31);
`else
      chk("sll31_extra_cycles", 32'(n), 32'd0);
`endif
      chk("sll31_result", bus.result, 32'h8000_0000);
      tick();

      // Backpressure
      bus.out_ready = 1'b0;
      offer(`ALU_ADD, 32'd1, 32'd2);
      tick();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("bp_result%0d", i), bus.result, 32'd3);
         chk($sformatf("bp_valid%0d", i), 32'(bus.out_valid), 32'd1);
         chk($sformatf("bp_in_ready%0d", i), 32'(bus.in_ready), 32'd0);
         tick();
      end
      offer(`ALU_XOR, 32'h0000_00F0, 32'h0000_00FF);
      bus.out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
      tick();
      chk("bp_next_result", bus.result, 32'h0000_000F);
      chk("bp_next_valid", 32'(bus.out_valid), 32'd1);

      // Illegal op then recovery
      offer(`ALU_XXX, 32'h0000_1234, 32'd0);
      tick();
      chk("ill_result", bus.result, 32'd0);
      chk("ill_flag", 32'(bus.illegal), 32'd1);
      offer(`ALU_COPY_B, 32'd0, 32'h0000_0055);
      tick();
      chk("copyb_flag", 32'(bus.illegal), 32'd0);
      chk("copyb_result", bus.result, 32'h0000_0055);
      bus.in_valid = 1'b0;
      tick();

      // Asynchronous reset mid-shift
      offer(`ALU_SLL, 32'd1, 32'd20);
      tick();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", 32'(bus.out_valid), 32'd0);
      chk("arst_result", bus.result, 32'd0);
      chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      rst = 1'b0;
      offer(`ALU_ADD, 32'd2, 32'd2);
      tick();
      bus.in_valid = 1'b0;
      chk("post_rst_add", bus.result, 32'd4);
      chk("post_rst_valid", 32'(bus.out_valid), 32'd1);
      tick();

`ifdef ALU_ITER_BARREL_EN
      // Back-to-back barrel shifts keep out_valid high
      offer(`ALU_SLL, 32'd1, 32'd31);
      tick();
      chk("bar_sll31", bus.result, 32'h8000_0000);
      offer(`ALU_SRA, 32'h8000_0000, 32'd8);
      tick();
      chk("bar_sra_valid", 32'(bus.out_valid), 32'd1);
      chk("bar_sra", bus.result, 32'hFF80_0000);
      offer(`ALU_SRL, 32'h8000_0000, 32'd8);
      tick();
      chk("bar_srl_valid", 32'(bus.out_valid), 32'd1);
      chk("bar_srl", bus.result, 32'h0080_0000);
      offer(`ALU_SLL, 32'h0000_00FF, 32'd4);
      tick();
      chk("bar_sll_valid", 32'(bus.out_valid), 32'd1);
      chk("bar_sll", bus.result, 32'h0000_0FF0);
      bus.in_valid = 1'b0;
      tick();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
